led_display_row_driver: RTL
===========================

// Module: led_display_row_driver
// PURPOSE
//  Consumer end of the row valid/ready stream produced by the display pattern generators.
//  Captures one rgb_row_t plus its 4-bit row address and serialises it onto a HUB75 panel:
//  shift clock, per-column upper/lower RGB bits, latch, output-enable and address.
//  Sits between the pattern generator and the panel connector pins; one row in flight at a time.
// PARAMETERS
//  SYS_CLK_FREQ    100_000_000  system clock in Hz (documentation/derivation only)
//  CLK_DIV         4            sys clocks per HUB75 shift-clock period; even, >= 2
//  LATCH_CYCLES    2            sys clocks hub_lat_out is held high
//  DISPLAY_CYCLES  2000         sys clocks spent in DISPLAY per row
//  SIMULATION      0            1 forces DISPLAY_CYCLES to 20 to shorten benches
// PORTS
//  clk_in            in   1                   system clock; single clock domain
//  n_reset_in        in   1                   synchronous, active-low reset
//  row_in            in   GL_RGB_ROW_W        rgb_row_t: top/bot x red/green/blue, GL_NUM_COL_PIXELS each
//  row_valid_in      in   1                   row_in/row_address_in valid
//  row_ready_out     out  1                   driver idle, will accept a row
//  row_address_in    in   4                   panel row pair for row_in
//  hub_clk_out       out  1                   HUB75 shift clock
//  hub_rgb_out       out  6                   {b1,g1,r1,b0,g0,r0}; *0 = top half, *1 = bottom half
//  hub_lat_out       out  1                   HUB75 latch, active high
//  hub_oe_n_out      out  1                   HUB75 output enable, active low
//  hub_addr_out      out  4                   HUB75 row address A..D
//  busy_out          out  1                   high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; row_ready_out=0, hub_clk_out=0, hub_rgb_out=0, hub_lat_out=0,
//   hub_oe_n_out=1, hub_addr_out=0, busy_out=0. Reset mid-row aborts; captured row discarded.
//  Handshake: row_ready_out is registered and is 1 in IDLE from the first cycle after reset release.
//   Transfer occurs when row_valid_in && row_ready_out; row_in and row_address_in are captured
//   into internal registers in that cycle; row_ready_out is 0 from the next cycle until IDLE is re-entered.
//   row_valid_in is ignored while row_ready_out=0; valid held high across a ready gap is not a second transfer.
//  FSM: IDLE -> SHIFT (on transfer) -> BLANK -> LATCH -> DISPLAY -> IDLE.
//   SHIFT: GL_NUM_COL_PIXELS columns, column GL_NUM_COL_PIXELS-1 first, down to 0. Per column:
//    hub_rgb_out updated on the first cycle with hub_clk_out=0; low for CLK_DIV/2 cycles, then
//    high for CLK_DIV/2 cycles. SHIFT lasts exactly GL_NUM_COL_PIXELS*CLK_DIV cycles, with exactly
//    GL_NUM_COL_PIXELS rising edges. hub_oe_n_out=1 throughout. hub_clk_out is 0 on exit.
//   BLANK: 1 cycle; hub_oe_n_out=1; hub_addr_out <= captured address; hub_rgb_out <= 0.
//   LATCH: hub_lat_out=1 for LATCH_CYCLES cycles, then 0.
//   DISPLAY: DISPLAY_CYCLES cycles; hub_oe_n_out=0 (see CONFIGURATION); return to IDLE with
//    hub_oe_n_out=1 in the same cycle row_ready_out rises.
//  hub_addr_out changes only in BLANK (never while OE is active); it holds between rows.
//  Column counter wraps from 0 to exit SHIFT; no wrap/overflow within a row. Address 15 -> next
//   row address 0 needs no special handling; the address is taken verbatim from row_address_in.
//  Per-row period: 1 (IDLE) + GL_NUM_COL_PIXELS*CLK_DIV + 1 + LATCH_CYCLES + DISPLAY_CYCLES.
// CONFIGURATION
//  LED_ROW_DRIVER_BRIGHTNESS_EN defined: adds input brightness_in [7:0], sampled on DISPLAY entry;
//   hub_oe_n_out=0 only for the first (DISPLAY_CYCLES*brightness_in)>>8 cycles of DISPLAY, 1 after;
//   DISPLAY length unchanged. brightness_in=0 -> OE never asserted.
//  Not defined: no brightness_in port; hub_oe_n_out=0 for the whole DISPLAY.
// TESTING
//  1 Reset hold 5 cycles, release -> all outputs at reset values; row_ready_out=1 on 1st cycle after.
//  2 CLK_DIV=4, row top.red=all 1s, others 0, addr=5 -> 256 SHIFT cycles, 64 hub_clk rises,
//    hub_rgb_out=6'b000001 each column; hub_addr_out=5 from BLANK; lat high 2 cycles.
//  3 Column order: top.green = 1 only at bit GL_NUM_COL_PIXELS-1 -> g0=1 only on 1st column shifted.
//  4 Generator-style stream (valid = ready delayed 1) for addrs 0..15, then 0 -> exactly one
//    transfer per row, addresses in order, no transfer while row_ready_out=0.
//  5 n_reset_in low mid-SHIFT (column 20) -> next cycle reset values; new row shifts from column 63.
//  6 BRIGHTNESS_EN, SIMULATION=1, brightness_in=128 -> OE low 10 of 20 DISPLAY cycles; 0 -> never low.

Source files
------------

// File: rtl/led_display_row_driver_if.sv
// Row stream between the display pattern generators and the HUB75 row driver.
// The package carries the shared panel geometry and the rgb_row_t layout.

package led_display_pkg;
  localparam int GL_NUM_COL_PIXELS = 64;

  // One colour plane set for half of the panel, one bit per column.
  typedef struct packed {
    logic [GL_NUM_COL_PIXELS-1:0] red;
    logic [GL_NUM_COL_PIXELS-1:0] green;
    logic [GL_NUM_COL_PIXELS-1:0] blue;
  } rgb_plane_t;

  // A full row pair: upper half (top) and lower half (bot) of the panel.
  typedef struct packed {
    rgb_plane_t top;
    rgb_plane_t bot;
  } rgb_row_t;

  localparam int GL_RGB_ROW_W = $bits(rgb_row_t);
endpackage

interface led_display_row_driver_if;
  import led_display_pkg::*;

  rgb_row_t    row_in;
  logic        row_valid_in;
  logic        row_ready_out;
  logic [3:0]  row_address_in;

  // Pattern generator side.
  modport master (
    output row_in,
    output row_valid_in,
    output row_address_in,
    input  row_ready_out
  );

  // Row driver side.
  modport slave (
    input  row_in,
    input  row_valid_in,
    input  row_address_in,
    output row_ready_out
  );
endinterface

// File: rtl/led_display_row_driver.sv
// HUB75 row driver: accepts one row over a valid/ready stream, shifts its 64
// columns out (highest column first), blanks, latches, then displays it.
// Optional feature macro: LED_ROW_DRIVER_BRIGHTNESS_EN adds brightness_in,
// which shortens the output-enable window inside the fixed DISPLAY period.
// All outputs are registered; next values are computed from the next state.

module led_display_row_driver
  import led_display_pkg::*;
#(
  parameter int SYS_CLK_FREQ   = 100_000_000,
  parameter int CLK_DIV        = 4,
  parameter int LATCH_CYCLES   = 2,
  parameter int DISPLAY_CYCLES = 2000,
  parameter int SIMULATION     = 0
) (
  input  logic                      clk_in,
  input  logic                      n_reset_in,
  led_display_row_driver_if.slave   row_bus,
`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
  input  logic [7:0]                brightness_in,
`endif
  output logic                      hub_clk_out,
  output logic [5:0]                hub_rgb_out,
  output logic                      hub_lat_out,
  output logic                      hub_oe_n_out,
  output logic [3:0]                hub_addr_out,
  output logic                      busy_out
);

  localparam int DISP_LEN = (SIMULATION != 0) ? 20 : DISPLAY_CYCLES;
  localparam int CNT_MAX  = (DISP_LEN > LATCH_CYCLES) ? DISP_LEN : LATCH_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int DIV_W    = $clog2(CLK_DIV);
  localparam int COL_W    = $clog2(GL_NUM_COL_PIXELS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(GL_NUM_COL_PIXELS - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(LATCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_LEN - 1);

  // Reject configurations the shift-clock generator cannot produce.
  if ((CLK_DIV < 2) || ((CLK_DIV % 2) != 0) || (SYS_CLK_FREQ < CLK_DIV) ||
      (LATCH_CYCLES < 1) || (DISP_LEN < 1)) begin : g_bad_cfg
    $error("led_display_row_driver: invalid parameter configuration");
  end

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

  state_t           state_r, state_nxt;
  logic [COL_W-1:0] col_r, col_nxt;
  logic [DIV_W-1:0] div_r, div_nxt;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic             take_s;

  rgb_row_t         row_r;
  rgb_row_t         row_sel_s;
  logic [3:0]       addr_r;

  logic             ready_r;
  logic             ready_nxt, busy_nxt, clk_nxt, lat_nxt, oe_n_nxt;
  logic [5:0]       rgb_nxt;
  logic [3:0]       addr_nxt;
  logic             oe_on_s;

  // HUB75 pin order {b1,g1,r1,b0,g0,r0} for one column of a row.
  function automatic logic [5:0] column_bits(input rgb_row_t r, input logic [COL_W-1:0] c);
    return {r.bot.blue[c], r.bot.green[c], r.bot.red[c],
            r.top.blue[c], r.top.green[c], r.top.red[c]};
  endfunction

  assign row_bus.row_ready_out = ready_r;

  // During the transfer cycle the first column comes straight from the bus.
  assign row_sel_s = take_s ? row_bus.row_in : row_r;

  // State and sequencing counters.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state_r <= ST_IDLE;
      col_r   <= {COL_W{1'b0}};
      div_r   <= {DIV_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_nxt;
      col_r   <= col_nxt;
      div_r   <= div_nxt;
      cnt_r   <= cnt_nxt;
    end
  end

  // Next state: one row walks IDLE->SHIFT->BLANK->LATCH->DISPLAY->IDLE.
  always_comb begin
    state_nxt = state_r;
    col_nxt   = col_r;
    div_nxt   = div_r;
    cnt_nxt   = cnt_r;
    take_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (row_bus.row_valid_in && ready_r) begin
          take_s    = 1'b1;
          state_nxt = ST_SHIFT;
          col_nxt   = COL_LAST;
          div_nxt   = {DIV_W{1'b0}};
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (div_r == DIV_LAST) begin
          div_nxt = {DIV_W{1'b0}};
          // Column 0 wrapping back to the top index ends the row.
          col_nxt = col_r - COL_W'(1);
          if (col_r == {COL_W{1'b0}}) begin
            state_nxt = ST_BLANK;
          end else begin
            state_nxt = ST_SHIFT;
          end
        end else begin
          div_nxt = div_r + DIV_W'(1);
        end
      end
      ST_BLANK: begin
        state_nxt = ST_LATCH;
        cnt_nxt   = {CNT_W{1'b0}};
      end
      ST_LATCH: begin
        if (cnt_r == LAT_LAST) begin
          state_nxt = ST_DISPLAY;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt   = cnt_r + CNT_W'(1);
        end
      end
      ST_DISPLAY: begin
        if (cnt_r == DISP_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          cnt_nxt   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        col_nxt   = {COL_W{1'b0}};
        div_nxt   = {DIV_W{1'b0}};
        cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Row and address capture on the handshake; reset discards a row in flight.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      row_r  <= '0;
      addr_r <= 4'd0;
    end else if (take_s) begin
      row_r  <= row_bus.row_in;
      addr_r <= row_bus.row_address_in;
    end else begin
      row_r  <= row_r;
      addr_r <= addr_r;
    end
  end

`ifdef LED_ROW_DRIVER_BRIGHTNESS_EN
  // OE stays on for DISPLAY cycle k while (k+1)*256 <= DISP_LEN*brightness,
  // i.e. for the first (DISP_LEN*brightness)>>8 cycles, without a divider.
  logic [CNT_W+7:0] prod_s, prod_r, lim_s;

  assign prod_s  = {8'd0, CNT_W'(DISP_LEN)} * {{CNT_W{1'b0}}, brightness_in};
  assign lim_s   = (state_r == ST_DISPLAY) ? prod_r : prod_s;
  assign oe_on_s = ({cnt_nxt + CNT_W'(1), 8'd0} <= lim_s);

  // Brightness product sampled on DISPLAY entry, held for the whole window.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      prod_r <= {(CNT_W+8){1'b0}};
    end else if ((state_r != ST_DISPLAY) && (state_nxt == ST_DISPLAY)) begin
      prod_r <= prod_s;
    end else begin
      prod_r <= prod_r;
    end
  end
`else
  assign oe_on_s = 1'b1;
`endif

  // Next values of the panel and handshake outputs, derived from the next state.
  always_comb begin
    ready_nxt = (state_nxt == ST_IDLE);
    busy_nxt  = (state_nxt != ST_IDLE);
    clk_nxt   = 1'b0;
    rgb_nxt   = hub_rgb_out;
    lat_nxt   = 1'b0;
    oe_n_nxt  = 1'b1;
    addr_nxt  = hub_addr_out;
    case (state_nxt)
      ST_SHIFT: begin
        clk_nxt = (div_nxt >= DIV_HALF);
        if (div_nxt == {DIV_W{1'b0}}) begin
          rgb_nxt = column_bits(row_sel_s, col_nxt);
        end else begin
          rgb_nxt = hub_rgb_out;
        end
      end
      ST_BLANK: begin
        rgb_nxt  = 6'd0;
        addr_nxt = addr_r;
      end
      ST_LATCH: begin
        lat_nxt = 1'b1;
      end
      ST_DISPLAY: begin
        oe_n_nxt = !oe_on_s;
      end
      ST_IDLE: begin
        oe_n_nxt = 1'b1;
      end
      default: begin
        rgb_nxt = 6'd0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      ready_r      <= 1'b0;
      busy_out     <= 1'b0;
      hub_clk_out  <= 1'b0;
      hub_rgb_out  <= 6'd0;
      hub_lat_out  <= 1'b0;
      hub_oe_n_out <= 1'b1;
      hub_addr_out <= 4'd0;
    end else begin
      ready_r      <= ready_nxt;
      busy_out     <= busy_nxt;
      hub_clk_out  <= clk_nxt;
      hub_rgb_out  <= rgb_nxt;
      hub_lat_out  <= lat_nxt;
      hub_oe_n_out <= oe_n_nxt;
      hub_addr_out <= addr_nxt;
    end
  end

endmodule
